// File: rtl/crc_tx_engine.sv
// crc_tx_engine: latches a 24-bit payload, computes CRC-16/XMODEM over its
// three bytes (one bit per clock), then sends the three payload bytes and
// the two CRC bytes as 8N1 UART frames paced by a 16x-baud tick strobe.
module crc_tx_engine #(
  parameter int          TICKS_PER_BIT = 16,
  parameter logic [15:0] POLY          = 16'h1021,
  parameter logic [15:0] INIT          = 16'h0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        tick_i,
  input  logic        start_i,
  input  logic [23:0] data_i,
  output logic        ready_o,
  output logic        tx_o,
  output logic [15:0] crc_o,
  output logic        done_o
);

  localparam int            TW        = (TICKS_PER_BIT > 1) ? $clog2(TICKS_PER_BIT) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    CALC,
    START,
    DATA,
    STOP
  } state_t;

  state_t        state;
  logic [23:0]   shreg;
  logic [15:0]   crc;
  logic [4:0]    calc_cnt;
  logic [TW-1:0] tick_cnt;
  logic [2:0]    bit_cnt;
  logic [2:0]    byte_idx;
  logic [7:0]    tx_byte;

  logic          fb;
  logic [15:0]   crc_next;
  logic [23:0]   shreg_rot;
  logic          tick_last;

  // Selects which byte goes on the line for a given position in the packet:
  // payload high/mid/low byte, then CRC high and low byte.
  function automatic logic [7:0] pick_byte(input logic [2:0]  idx,
                                           input logic [23:0] payload,
                                           input logic [15:0] c);
    logic [7:0] b;
    case (idx)
      3'd0:    b = payload[23:16];
      3'd1:    b = payload[15:8];
      3'd2:    b = payload[7:0];
      3'd3:    b = c[15:8];
      default: b = c[7:0];
    endcase
    return b;
  endfunction

  // One CRC step on the payload MSB, the payload rotated by one (after 24
  // rotations it is back in its original order for transmission), and the
  // strobe that marks the final tick of the current UART bit.
  always_comb begin
    fb        = crc[15] ^ shreg[23];
    crc_next  = {crc[14:0], 1'b0} ^ (fb ? POLY : 16'h0000);
    shreg_rot = {shreg[22:0], shreg[23]};
    tick_last = tick_i && (tick_cnt == TICK_LAST);
  end

  // Main sequencer: accept, bit-serial CRC, then five UART frames with
  // registered line, ready and done outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= IDLE;
      shreg    <= 24'h000000;
      crc      <= 16'h0000;
      crc_o    <= 16'h0000;
      calc_cnt <= 5'd0;
      tick_cnt <= '0;
      bit_cnt  <= 3'd0;
      byte_idx <= 3'd0;
      tx_byte  <= 8'h00;
      tx_o     <= 1'b1;
      ready_o  <= 1'b1;
      done_o   <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          tx_o <= 1'b1;
          if (start_i && ready_o) begin
            shreg    <= data_i;
            crc      <= INIT;
            calc_cnt <= 5'd0;
            ready_o  <= 1'b0;
            state    <= CALC;
          end
        end

        CALC: begin
          crc      <= crc_next;
          shreg    <= shreg_rot;
          calc_cnt <= calc_cnt + 5'd1;
          if (calc_cnt == 5'd23) begin
            crc_o    <= crc_next;
            calc_cnt <= 5'd0;
            byte_idx <= 3'd0;
            bit_cnt  <= 3'd0;
            tick_cnt <= '0;
            tx_byte  <= shreg_rot[23:16];
            tx_o     <= 1'b0;
            state    <= START;
          end
        end

        START: begin
          if (tick_last) begin
            tick_cnt <= '0;
            bit_cnt  <= 3'd0;
            tx_o     <= tx_byte[0];
            tx_byte  <= {1'b0, tx_byte[7:1]};
            state    <= DATA;
          end else if (tick_i) begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end

        DATA: begin
          if (tick_last) begin
            tick_cnt <= '0;
            if (bit_cnt == 3'd7) begin
              bit_cnt <= 3'd0;
              tx_o    <= 1'b1;
              state   <= STOP;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              tx_o    <= tx_byte[0];
              tx_byte <= {1'b0, tx_byte[7:1]};
            end
          end else if (tick_i) begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end

        STOP: begin
          if (tick_last) begin
            tick_cnt <= '0;
            if (byte_idx < 3'd4) begin
              byte_idx <= byte_idx + 3'd1;
              tx_byte  <= pick_byte(byte_idx + 3'd1, shreg, crc);
              tx_o     <= 1'b0;
              state    <= START;
            end else begin
              byte_idx <= 3'd0;
              done_o   <= 1'b1;
              ready_o  <= 1'b1;
              state    <= IDLE;
            end
          end else if (tick_i) begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_crc_tx_engine.sv
// tb_crc_tx_engine: drives payloads into crc_tx_engine, decodes the UART
// line by counting tick strobes, and compares against a polynomial-division
// CRC model and the expected five-byte packet.
module tb_crc_tx_engine;

  logic        clk;
  logic        rst;
  logic        tick;
  logic        start;
  logic [23:0] data;
  logic        ready;
  logic        tx;
  logic [15:0] crc;
  logic        done;

  int checks = 0;
  int errors = 0;
  bit tick_en = 1'b1;
  int tick_count = 0;

  crc_tx_engine dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .tick_i (tick),
    .start_i(start),
    .data_i (data),
    .ready_o(ready),
    .tx_o   (tx),
    .crc_o  (crc),
    .done_o (done)
  );

  // 100 MHz clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Tick strobe every 4th clock, changed on the falling edge, gated by tick_en
  initial begin : tick_gen
    int phase;
    phase = 0;
    tick  = 1'b0;
    forever begin
      @(negedge clk);
      if (tick_en && phase == 3) begin
        tick = 1'b1;
        tick_count++;
      end else begin
        tick = 1'b0;
      end
      phase = (phase + 1) % 4;
    end
  end

  // CRC as the remainder of (payload * x^16) divided by x^16 + POLY
  function automatic logic [15:0] ref_crc(input logic [23:0] d);
    logic [39:0] m;
    m = {d, 16'h0000};
    for (int i = 39; i >= 16; i--)
      if (m[i]) m = m ^ (40'h11021 << (i - 16));
    return m[15:0];
  endfunction

  // Bytes in transmission order: payload high to low, then CRC high, low
  function automatic logic [39:0] ref_stream(input logic [23:0] d);
    return {d, ref_crc(d)};
  endfunction

  task automatic wait_ticks(input int n, output bit ok);
    int seen;
    seen = 0;
    for (int c = 0; c < 5000 && seen < n; c++) begin
      @(posedge clk);
      if (tick === 1'b1) seen++;
    end
    ok = (seen >= n);
    #1;
  endtask

  task automatic recv_frame(output logic [7:0] b, output bit ok);
    bit t;
    int c;
    ok = 1'b1;
    b  = 8'h00;
    for (c = 0; c < 5000; c++) begin
      if (tx === 1'b0) break;
      @(negedge clk);
    end
    if (c >= 5000) begin
      ok = 1'b0;
      return;
    end
    wait_ticks(8, t);
    if (!t || tx !== 1'b0) ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      wait_ticks(16, t);
      if (!t) ok = 1'b0;
      b[i] = tx;
    end
    wait_ticks(16, t);
    if (!t || tx !== 1'b1) ok = 1'b0;
  endtask

  task automatic recv_stream(output logic [39:0] s, output bit ok);
    logic [7:0] b;
    bit         fok;
    ok = 1'b1;
    s  = 40'h0;
    for (int i = 0; i < 5; i++) begin
      recv_frame(b, fok);
      if (!fok) ok = 1'b0;
      s = {s[31:0], b};
    end
  endtask

  task automatic wait_done(output int cnt, output logic rdy);
    cnt = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (done === 1'b1) cnt++;
    end
    rdy = ready;
  endtask

  task automatic start_packet(input logic [23:0] d, output int lat);
    @(negedge clk);
    data  = d;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (tx === 1'b0) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic applyStimulus_packet_checks(input logic [23:0] d, input logic [15:0] crc_exp,
                                             input string name);
    int          lat;
    logic [39:0] s;
    bit          ok;
    int          dc;
    logic        rdy;
    start_packet(d, lat);
    checks++;
    if (lat !== 24) begin
      errors++;
      $display("[TB] FAIL %s latency got %0d exp 24", name, lat);
    end
    checks++;
    if (crc !== crc_exp) begin
      errors++;
      $display("[TB] FAIL %s crc_o got %h exp %h", name, crc, crc_exp);
    end
    recv_stream(s, ok);
    checks++;
    if (!ok || s !== ref_stream(d)) begin
      errors++;
      $display("[TB] FAIL %s stream got %h framing_ok %0d exp %h", name, s, ok, ref_stream(d));
    end
    wait_done(dc, rdy);
    checks++;
    if (dc !== 1) begin
      errors++;
      $display("[TB] FAIL %s done pulses got %0d exp 1", name, dc);
    end
    checks++;
    if (rdy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL %s ready after done got %b exp 1", name, rdy);
    end
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b0;
    data  = 24'h0;
    repeat (3) @(negedge clk);
    checks++;
    if (tx !== 1'b1) begin errors++; $display("[TB] FAIL reset tx got %b exp 1", tx); end
    checks++;
    if (ready !== 1'b1) begin errors++; $display("[TB] FAIL reset ready got %b exp 1", ready); end
    checks++;
    if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset done got %b exp 0", done); end
    checks++;
    if (crc !== 16'h0000) begin errors++; $display("[TB] FAIL reset crc got %h exp 0000", crc); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_known_vectors();
    applyStimulus_packet_checks(24'h000001, 16'h1021, "vec_000001");
    applyStimulus_packet_checks(24'h000002, 16'h2042, "vec_000002");
    applyStimulus_packet_checks(24'h000000, 16'h0000, "vec_000000");
    applyStimulus_packet_checks(24'h486921, ref_crc(24'h486921), "vec_Hi!");
  endtask

  task automatic test_random();
    logic [23:0] d;
    for (int i = 0; i < 3; i++) begin
      d = 24'($urandom);
      applyStimulus_packet_checks(d, ref_crc(d), "random");
    end
  endtask

  task automatic test_ignore_start();
    logic [23:0] d;
    int          lat;
    logic [39:0] s;
    bit          ok;
    bit          ready_bad;
    int          dc;
    logic        rdy;
    d = 24'($urandom);
    ready_bad = 1'b0;
    start_packet(d, lat);
    fork
      recv_stream(s, ok);
      begin
        for (int i = 0; i < 6; i++) begin
          repeat (300) @(negedge clk);
          data  = 24'($urandom);
          start = 1'b1;
          if (ready !== 1'b0) ready_bad = 1'b1;
          @(negedge clk);
          start = 1'b0;
        end
      end
    join
    checks++;
    if (ready_bad) begin errors++; $display("[TB] FAIL ignore_start ready got 1 exp 0 while busy"); end
    checks++;
    if (!ok || s !== ref_stream(d)) begin
      errors++;
      $display("[TB] FAIL ignore_start stream got %h framing_ok %0d exp %h", s, ok, ref_stream(d));
    end
    checks++;
    if (crc !== ref_crc(d)) begin
      errors++;
      $display("[TB] FAIL ignore_start crc_o got %h exp %h", crc, ref_crc(d));
    end
    wait_done(dc, rdy);
    checks++;
    if (dc !== 1 || rdy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ignore_start done got %0d ready %b exp 1 1", dc, rdy);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [23:0] d;
    int          lat;
    int          t0;
    logic        exp_bit;
    d = 24'($urandom);
    start_packet(d, lat);
    t0 = tick_count;
    for (int c = 0; c < 20000; c++) begin
      @(negedge clk);
      if (tick_count - t0 >= 568) break;
    end
    exp_bit = ref_crc(d)[12];
    checks++;
    if (tx !== exp_bit) begin
      errors++;
      $display("[TB] FAIL reset_mid line before reset got %b exp %b", tx, exp_bit);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (tx !== 1'b1 || ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_mid immediate tx %b ready %b exp 1 1", tx, ready);
    end
    checks++;
    if (done !== 1'b0 || crc !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL reset_mid done %b crc %h exp 0 0000", done, crc);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    d = 24'($urandom);
    applyStimulus_packet_checks(d, ref_crc(d), "after_reset");
  endtask

  task automatic test_tick_stall();
    logic [23:0] d;
    int          lat;
    int          t0;
    logic [39:0] s;
    bit          ok;
    bit          hold_bad;
    logic        lvl;
    int          dc;
    logic        rdy;
    d = 24'($urandom);
    hold_bad = 1'b0;
    start_packet(d, lat);
    t0 = tick_count;
    fork
      recv_stream(s, ok);
      begin
        for (int c = 0; c < 5000; c++) begin
          @(negedge clk);
          if (tick_count - t0 >= 200) break;
        end
        tick_en = 1'b0;
        @(negedge clk);
        lvl = tx;
        for (int i = 0; i < 1000; i++) begin
          @(negedge clk);
          if (tx !== lvl) hold_bad = 1'b1;
        end
        tick_en = 1'b1;
      end
    join
    checks++;
    if (hold_bad) begin errors++; $display("[TB] FAIL tick_stall line changed exp held at %b", lvl); end
    checks++;
    if (!ok || s !== ref_stream(d)) begin
      errors++;
      $display("[TB] FAIL tick_stall stream got %h framing_ok %0d exp %h", s, ok, ref_stream(d));
    end
    wait_done(dc, rdy);
    checks++;
    if (dc !== 1 || rdy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL tick_stall done got %0d ready %b exp 1 1", dc, rdy);
    end
  endtask

  task automatic test_back_to_back();
    logic [23:0] d1;
    logic [23:0] d2;
    int          lat;
    logic [39:0] s;
    bit          ok;
    bit          seen;
    int          dc;
    logic        rdy;
    d1 = 24'($urandom);
    d2 = 24'($urandom);
    start_packet(d1, lat);
    recv_stream(s, ok);
    checks++;
    if (!ok || s !== ref_stream(d1)) begin
      errors++;
      $display("[TB] FAIL b2b first stream got %h framing_ok %0d exp %h", s, ok, ref_stream(d1));
    end
    @(negedge clk);
    data  = d2;
    start = 1'b1;
    seen  = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen || ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL b2b done edge seen %0d ready %b exp 1 1", seen, ready);
    end
    @(negedge clk);
    checks++;
    if (ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b accept after done ready got %b exp 0", ready);
    end
    start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (tx === 1'b0) begin
        lat = k;
        break;
      end
    end
    checks++;
    if (lat !== 24 || crc !== ref_crc(d2)) begin
      errors++;
      $display("[TB] FAIL b2b second latency %0d crc %h exp 24 %h", lat, crc, ref_crc(d2));
    end
    recv_stream(s, ok);
    checks++;
    if (!ok || s !== ref_stream(d2)) begin
      errors++;
      $display("[TB] FAIL b2b second stream got %h framing_ok %0d exp %h", s, ok, ref_stream(d2));
    end
    wait_done(dc, rdy);
    checks++;
    if (dc !== 1 || rdy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL b2b second done got %0d ready %b exp 1 1", dc, rdy);
    end
  endtask

  // Scenario sequence followed by the summary line
  initial begin
    test_reset();
    test_known_vectors();
    test_random();
    test_ignore_start();
    test_reset_mid_frame();
    test_tick_stall();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/crc_tx_engine.md
Name: crc_tx_engine

Overview:
Transmit-side counterpart of the CRC receive engine. Accepts a 24-bit payload and computes CRC-16/XMODEM over its 3 bytes. It then serialises 5 UART frames (3 payload bytes followed by 2 CRC bytes) on tx_o, paced by the shared 16x-baud tick. Its output drives the receive engine's serial input directly.

Parameters:
TICKS_PER_BIT, 16, tick_i strobes per UART bit (start, data and stop bits alike)
POLY, 16'h1021, CRC generator polynomial (implicit x^16)
INIT, 16'h0000, CRC register value loaded on each accepted payload

Ports:
clk_i  input  1  system clock
rst_i  input  1  asynchronous, active-high reset
tick_i  input  1  one-clk_i-wide strobe at TICKS_PER_BIT x baud, synchronous to clk_i
start_i  input  1  request to send data_i; honoured only while ready_o=1
data_i  input  24  payload; byte 2 = data_i[23:16] is sent first
ready_o  output  1  high in IDLE; start_i accepted on a clock edge where start_i and ready_o are both 1
tx_o  output  1  UART serial line; idle high
crc_o  output  16  CRC of the latched payload; valid from CALC exit until the next accept
done_o  output  1  one-clock pulse at the end of the last stop bit

Behaviour:
- Reset (async, any state): state=IDLE, tx_o=1, ready_o=1, done_o=0, crc_o=0, all counters=0. Takes effect immediately, including mid-frame.
- States: IDLE -> CALC -> START -> DATA -> STOP -> (START of next byte | IDLE).
- IDLE: tx_o=1. On accept, latch data_i into a 24-bit shift register, load CRC register with INIT, set ready_o=0, go to CALC.
- CALC: 24 clk_i cycles, 1 payload bit per cycle, MSB (data_i[23]) first.
  - Per bit: fb = crc[15] ^ bit; crc = {crc[14:0],1'b0} ^ (fb ? POLY : 0).
  - No reflection and no final XOR.
  - crc_o updates when CALC exits. tick_i is ignored during CALC.
- Byte sequence (index 0..4): data[23:16], data[15:8], data[7:0], crc[15:8], crc[7:0].
- START: tx_o=0. On entry, tick counter is cleared. Exit when TICKS_PER_BIT tick_i strobes have been counted.
- DATA: 8 bits, LSB first, each held for TICKS_PER_BIT ticks.
- STOP: tx_o=1 for TICKS_PER_BIT ticks. Then:
  - if byte index < 4: increment index, enter START for the next byte (no idle gap);
  - else: pulse done_o, set ready_o=1, go to IDLE.
- tx_o is a registered output and changes only on the clk_i edge that counts the final tick of the previous bit, or on START entry.
- Total line time after CALC: 5 x 10 x TICKS_PER_BIT ticks (800 at default).
- start_i while ready_o=0 is ignored; data_i is not sampled.
- A new start_i on the same edge done_o pulses is not accepted (ready_o is still 0 on that edge). It is accepted on the following edge.
- A tick_i arriving on the START-entry edge is not counted.
- Counter widths:
  - tick counter: clog2(TICKS_PER_BIT) bits, wraps to 0 at TICKS_PER_BIT-1;
  - bit counter: 3 bits;
  - byte index: 3 bits, range 0..4 only.

Test Plan:
- Payload 24'h000001, start_i 1 cycle -> after 24 clocks crc_o=16'h1021. tx_o bytes decode as 00,00,01,10,21 (each start=0, stop=1, 16 ticks per bit). done_o pulses once, then ready_o=1.
- Payload 24'h000002 -> crc_o=16'h2042. Payload 24'h000000 -> crc_o=16'h0000, bytes 00,00,00,00,00.
- Loopback into crc_rx_engine (shared clk_i/tick_i, rx_en_i=1) with payload "Hi!" (24'h486921) -> receiver out_o=24'h486921, error_o=0. Force one flipped tx bit -> error_o=1.
- start_i pulsed repeatedly mid-transmission with different data_i -> no change to tx stream or crc_o. ready_o stays 0 until done_o.
- rst_i asserted during DATA of byte 3 -> tx_o=1 and ready_o=1 immediately (before next clk_i edge). A subsequent start_i transmits a full, correct 5-byte packet.
- tick_i held 0 for 1000 clocks mid-bit -> tx_o holds its level and no counters advance. Transmission resumes correctly when ticks restart.
